// File: rtl/tx_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tx_frame_arbiter
// Shares the single UART TX FIFO write port among NUM_REQ response sources.
// Each source asks for a 1- or 2-byte frame. A winner is picked, its frame is
// latched, and the bytes are pushed LSB first. The pusher stalls while
// FIFO_FULL is high, and frames from different sources never interleave.
//
// Ports
//   CLK        system clock
//   RST        asynchronous, active-low reset
//   REQ        per-requester frame request, held until the matching ACK bit
//   REQ_LEN    per-requester length: 0 = one byte, 1 = two bytes
//   REQ_DATA   requester i frame at [i*2*DATA_WIDTH +: 2*DATA_WIDTH]
//   FIFO_FULL  TX FIFO full flag
//   ACK        one-hot pulse in the cycle the last byte of a frame is pushed
//   TX_P_Data  byte to the FIFO, 0 when TX_D_VLD is low
//   TX_D_VLD   FIFO write strobe
//   BUSY       high whenever a frame is in progress
//
// Build option
//   TX_ARB_FIXED_PRIO_EN  defined: fixed priority, lowest index always wins,
//                         and there is no pointer register.
//                         undefined: round-robin with a pointer that advances
//                         when a frame completes.
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | no frame in progress; arbitrate and latch on grant
// SEND_LSB | push latched LSB when FIFO has room
// SEND_MSB | push latched MSB when FIFO has room, then ACK
// ---------------------------------------------------------------------------
module tx_frame_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 3
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic [NUM_REQ-1:0]              REQ,
   input  logic [NUM_REQ-1:0]              REQ_LEN,
   input  logic [NUM_REQ*2*DATA_WIDTH-1:0] REQ_DATA,
   input  logic                            FIFO_FULL,
   output logic [NUM_REQ-1:0]              ACK,
   output logic [DATA_WIDTH-1:0]           TX_P_Data,
   output logic                            TX_D_VLD,
   output logic                            BUSY
);

   localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND_LSB = 2'd1,
      SEND_MSB = 2'd2
   } state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic [IDX_W-1:0]          r_idx;
   logic                      r_len;
   logic [2*DATA_WIDTH-1:0]   r_data;
   logic [IDX_W-1:0]          w_win_idx;
   logic                      w_any;
   logic                      w_done;

`ifdef TX_ARB_FIXED_PRIO_EN
   // Descending scan, so the lowest set index is the last one written and wins.
   always_comb begin
      w_any     = |REQ;
      w_win_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (REQ[i]) w_win_idx = IDX_W'(i);
      end
   end
`else
   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] w_j;

   // Scan offsets from the highest down to the lowest, so the set bit closest
   // to the pointer (searching upward with wrap) is written last and wins.
   always_comb begin
      w_any     = |REQ;
      w_win_idx = '0;
      w_j       = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_j = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
         if (REQ[w_j]) w_win_idx = w_j;
      end
   end

   // The pointer moves only when a frame completes. A frame cut short by
   // reset leaves it at its reset value.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_ptr <= '0;
      end else if (w_done) begin
         r_ptr <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
      end
   end
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_len   <= 1'b0;
         r_data  <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_any) begin
            r_idx  <= w_win_idx;
            r_len  <= REQ_LEN[w_win_idx];
            r_data <= REQ_DATA[int'(w_win_idx)*2*DATA_WIDTH +: 2*DATA_WIDTH];
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      TX_D_VLD  = 1'b0;
      TX_P_Data = '0;
      w_done    = 1'b0;
      ACK       = '0;
      case (r_state)
         IDLE: begin
            if (w_any) w_next = SEND_LSB;
         end
         SEND_LSB: begin
            if (!FIFO_FULL) begin
               TX_D_VLD  = 1'b1;
               TX_P_Data = r_data[DATA_WIDTH-1:0];
               if (r_len) begin
                  w_next = SEND_MSB;
               end else begin
                  w_done = 1'b1;
                  w_next = IDLE;
               end
            end
         end
         SEND_MSB: begin
            if (!FIFO_FULL) begin
               TX_D_VLD  = 1'b1;
               TX_P_Data = r_data[2*DATA_WIDTH-1:DATA_WIDTH];
               w_done    = 1'b1;
               w_next    = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
      if (w_done) ACK = NUM_REQ'(1) << r_idx;
   end

   assign BUSY = (r_state != IDLE);

endmodule

// File: tb/tb_tx_frame_arbiter.sv
module tb_tx_frame_arbiter;

   localparam int N  = 3;
   localparam int DW = 8;

   logic              CLK = 1'b0;
   logic              RST;
   logic [N-1:0]      REQ;
   logic [N-1:0]      REQ_LEN;
   logic [N*2*DW-1:0] REQ_DATA;
   logic              FIFO_FULL;
   logic [N-1:0]      ACK;
   logic [DW-1:0]     TX_P_Data;
   logic              TX_D_VLD;
   logic              BUSY;

   tx_frame_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_LEN(REQ_LEN), .REQ_DATA(REQ_DATA),
      .FIFO_FULL(FIFO_FULL), .ACK(ACK), .TX_P_Data(TX_P_Data),
      .TX_D_VLD(TX_D_VLD), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [N-1:0]  a;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: a frame is a list of bytes; it finishes after len+1
   // cycles without FIFO_FULL; the next search starts just past the winner.
   bit   m_busy = 0;
   int   m_left = 0;
   int   m_idx  = 0;
   int   m_ptr  = 0;

   always @(posedge CLK) begin
      if (!RST) begin
         m_busy = 0;
         m_ptr  = 0;
         exp_q.delete();
      end else if (!m_busy) begin
         if (REQ != 0) begin
            int w;
            logic [15:0] f;
            w = -1;
            for (int k = 0; k < N; k++) begin
               int j;
               j = (m_ptr + k) % N;
               if (w < 0 && REQ[j]) w = j;
            end
            f = REQ_DATA[w*16 +: 16];
            if (REQ_LEN[w]) begin
               exp_q.push_back('{d: f[7:0],  a: '0});
               exp_q.push_back('{d: f[15:8], a: N'(1 << w)});
            end else begin
               exp_q.push_back('{d: f[7:0],  a: N'(1 << w)});
            end
            m_busy = 1;
            m_idx  = w;
            m_left = REQ_LEN[w] ? 2 : 1;
         end
      end else if (!FIFO_FULL) begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 0;
`ifdef TX_ARB_FIXED_PRIO_EN
            m_ptr = 0;
`else
            m_ptr = (m_idx + 1) % N;
`endif
         end
      end
   end

   // Monitor: compares every cycle at the falling edge.
   always @(negedge CLK) begin
      if (!RST) begin
         checks++;
         if (TX_D_VLD !== 1'b0 || TX_P_Data !== '0 || ACK !== '0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: vld=%b data=%h ack=%b busy=%b, required all 0",
                     TX_D_VLD, TX_P_Data, ACK, BUSY);
         end
      end else begin
         checks++;
         if (BUSY !== m_busy || TX_D_VLD !== (m_busy && !FIFO_FULL)) begin
            errors++;
            $display("FAIL busy_vld: busy=%b vld=%b full=%b, required busy=%b vld=%b",
                     BUSY, TX_D_VLD, FIFO_FULL, m_busy, m_busy && !FIFO_FULL);
         end
         if (TX_D_VLD === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_byte: data=%h ack=%b, required no write", TX_P_Data, ACK);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (TX_P_Data !== e.d || ACK !== e.a) begin
                  errors++;
                  $display("FAIL byte: data=%h ack=%b, required data=%h ack=%b",
                           TX_P_Data, ACK, e.d, e.a);
               end
            end
         end else begin
            checks++;
            if (ACK !== '0 || TX_P_Data !== '0) begin
               errors++;
               $display("FAIL idle_outputs: data=%h ack=%b, required 0 and 0", TX_P_Data, ACK);
            end
         end
      end
   end

   int rr_mode   = 0;   // 0 drop REQ on ACK, 1 keep same request, 2 random
   bit rand_req  = 0;
   bit rand_full = 0;

   task automatic new_frame(input int i);
      REQ[i]           = 1'b1;
      REQ_LEN[i]       = 1'($urandom_range(0, 1));
      REQ_DATA[i*16 +: 16] = 16'($urandom);
   endtask

   task automatic set_req(input int i, input bit len, input logic [15:0] d);
      REQ[i]           = 1'b1;
      REQ_LEN[i]       = len;
      REQ_DATA[i*16 +: 16] = d;
   endtask

   // One clock: sample ACK mid-cycle, then update requesters after the edge.
   task automatic tick();
      logic [N-1:0] ack_s;
      @(negedge CLK);
      ack_s = ACK;
      @(posedge CLK);
      #1;
      for (int i = 0; i < N; i++) begin
         if (ack_s[i]) begin
            if (rr_mode == 1) begin
               REQ[i] = 1'b1;
            end else if (rr_mode == 2 && $urandom_range(0, 1) == 1) begin
               new_frame(i);
            end else begin
               REQ[i] = 1'b0;
            end
         end else if (rand_req && !REQ[i] && $urandom_range(0, 3) == 0) begin
            new_frame(i);
         end
      end
      if (rand_full) FIFO_FULL = ($urandom_range(0, 2) == 0);
   endtask

   initial begin
      RST = 1'b0; REQ = '0; REQ_LEN = '0; REQ_DATA = '0; FIFO_FULL = 1'b0;
      repeat (3) tick();
      RST = 1'b1;
      tick();

      set_req(0, 1'b0, 16'h00A5);
      repeat (4) tick();

      set_req(1, 1'b1, 16'h1234);
      repeat (5) tick();

      set_req(0, 1'b0, 16'h00A0);
      set_req(1, 1'b0, 16'h00B1);
      set_req(2, 1'b0, 16'h00C2);
      rr_mode = 1;
      repeat (8) tick();
      rr_mode = 0;
      repeat (8) tick();

      set_req(2, 1'b1, 16'hBEEF);
      tick();
      tick();
      FIFO_FULL = 1'b1;
      set_req(0, 1'b0, 16'h0077);
      repeat (3) tick();
      FIFO_FULL = 1'b0;
      repeat (6) tick();

      set_req(1, 1'b1, 16'hCAFE);
      tick();
      tick();
      FIFO_FULL = 1'b1;
      tick();
      RST = 1'b0;
      REQ = 3'b000;
      set_req(2, 1'b0, 16'h0042);
      FIFO_FULL = 1'b0;
      repeat (2) tick();
      RST = 1'b1;
      repeat (4) tick();

      set_req(0, 1'b1, 16'h5A5A);
      tick();
      REQ[0] = 1'b0;
      repeat (4) tick();

      rand_req = 1; rand_full = 1; rr_mode = 2;
      for (int c = 0; c < 1500; c++) begin
         tick();
         if (c == 700) begin
            RST = 1'b0;
            tick();
            tick();
            RST = 1'b1;
         end
      end

      rand_req = 0; rand_full = 0; rr_mode = 0; FIFO_FULL = 1'b0;
      for (int c = 0; c < 40 && (REQ != 0 || BUSY); c++) tick();
      tick();
      checks++;
      if (REQ != 0 || BUSY !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: req=%b busy=%b pending=%0d, required 0 0 0",
                  REQ, BUSY, exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
